sram_mem_ctrl: RTL and testbench
================================

Name: sram_mem_ctrl

Overview:
- Memory-stage responder between the EXE/MEM pipeline outputs and an external 16-bit asynchronous SRAM.
- Produces the 32-bit load result that the MEM/WB register latches as its memory-result input.
- Performs each 32-bit access as two 16-bit SRAM transfers, with a programmable number of wait cycles per transfer.
- Holds `ready` low while busy so the hazard/freeze logic stalls every pipeline register.

Parameters:
- WAIT_CYCLES, 1, extra cycles each 16-bit transfer is held (0..15). Each transfer lasts WAIT_CYCLES+1 cycles.
- ADDR_OFFSET, 1024, byte address of data-memory base. It is subtracted from alu_res before the SRAM address is formed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from EXE/MEM (mem_r).
- wr_en  in  1  store request from EXE/MEM (mem_w).
- address  in  32  byte address (ALU result).
- wr_data  in  32  store data (Rm value).
- rd_data  out  32  load result, to MEM/WB mem_res input.
- ready  out  1  high = no access pending or access completing this cycle; low = freeze pipeline.
- sram_addr  out  18  SRAM half-word address.
- sram_dq  inout  16  SRAM data bus.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Address arithmetic:
  - word = (address - ADDR_OFFSET) >> 2, computed modulo 2^32.
  - Only word[16:0] is used; higher bits are silently dropped (wrap-around).
  - Low half: sram_addr = {word[16:0], 1'b0}. High half: sram_addr = {word[16:0], 1'b1}.
- Request capture:
  - address, wr_data and the request type are registered on the IDLE->access transition.
  - They are held constant for the whole access, independent of later input changes.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE: wr_en=1 -> WR_LO. Else rd_en=1 -> RD_LO. Else stay.
  - rd_en and wr_en both high is illegal upstream; write takes priority.
  - RD_LO/RD_HI/WR_LO/WR_HI: stay for WAIT_CYCLES+1 cycles, counted by a wait counter cleared on each state entry.
  - RD_LO -> RD_HI -> DONE. WR_LO -> WR_HI -> DONE.
  - DONE: lasts exactly 1 cycle, then -> IDLE. Inputs are ignored in DONE, because the same instruction is still presented.
- ready:
  - IDLE: ready = ~(rd_en | wr_en), combinational.
  - Access states: ready = 0.
  - DONE: ready = 1.
  - The pipeline therefore advances on the DONE cycle edge, and the next instruction's request is seen in IDLE.
- Latency, with IDLE-with-request as cycle 0: ready rises in cycle 2*(WAIT_CYCLES+1)+1. Default WAIT_CYCLES=1 gives cycle 5.
- Reads:
  - sram_we_n = 1 and sram_dq is high-Z.
  - The bus is sampled on the last cycle of RD_LO into rd_data[15:0] and on the last cycle of RD_HI into rd_data[31:16].
  - rd_data is registered and holds its value until the next read overwrites it. Writes do not change it.
- Writes:
  - sram_we_n = 0 for every cycle of WR_LO/WR_HI.
  - sram_dq drives wr_data[15:0] in WR_LO and wr_data[31:16] in WR_HI.
  - sram_addr is stable for each whole transfer.
- SRAM bus when idle: in IDLE/DONE, sram_we_n = 1, sram_dq = high-Z, and sram_addr holds its last value (0 after reset).
- Reset values: state=IDLE, counter=0, rd_data=0, sram_addr=0, sram_we_n=1, sram_dq high-Z.
  - ready follows its combinational rule from IDLE.
- Reset mid-access: the state machine aborts to IDLE at the next edge. A partial write may remain in SRAM; this is acceptable.

Decomposition:
- Constants.v, shared include: add SRAM_ADDR_LEN=18, SRAM_DATA_LEN=16, and the state encodings (3-bit localparams).
- Reuse existing: REGISTER_FILE_LEN.
- The two rd_data halves use the existing Register module with ld gated by read-sample strobes.
- One new sub-module: sram_wait_counter.
  - 4-bit up-counter with synchronous clr.
  - Outputs done when count == WAIT_CYCLES.

Test Plan:
- Store: rst 2 cycles; wr_en=1, address=1024+8, wr_data=32'hDEADBEEF.
  - sram_addr=4 with dq=16'hBEEF for 2 cycles, then sram_addr=5 with dq=16'hDEAD for 2 cycles.
  - we_n low for all 4 cycles; ready=1 in cycle 5.
- Load from the same word: SRAM model returns the stored values.
  - rd_data=32'hDEADBEEF when ready=1 in cycle 5; we_n stays 1 and dq is high-Z throughout.
- Back-to-back: store to address 1028 with 32'h12345678, then immediately load from 1028.
  - ready pulses once per access; no lost or merged request; load returns 32'h12345678.
- Simultaneous rd_en=wr_en=1:
  - controller enters WR_LO; rd_data unchanged from its previous value (e.g. 32'hDEADBEEF).
- Wrap and latency sweep:
  - address=1024 + 4*2^17 maps to sram_addr=0.
  - Repeat the load with WAIT_CYCLES=0 (ready in cycle 3) and WAIT_CYCLES=3 (ready in cycle 9).
- Reset mid-write: assert rst in the second cycle of WR_HI.
  - Next cycle: IDLE, we_n=1, dq high-Z, rd_data=0; ready=1 with no request.

Source files
------------

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared widths, state encoding and address helper for the memory-stage SRAM controller.
// Imported by the top controller and its wait counter.
package sram_mem_ctrl_pkg;

    localparam int REGISTER_FILE_LEN = 32;
    localparam int SRAM_ADDR_LEN     = 18;
    localparam int SRAM_DATA_LEN     = 16;
    localparam int SRAM_WORD_LEN     = SRAM_ADDR_LEN - 1;
    localparam int WAIT_CNT_LEN      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Word index inside the data memory; bits above the SRAM word range wrap away.
    function automatic logic [SRAM_WORD_LEN-1:0] sram_word(
        input logic [REGISTER_FILE_LEN-1:0] byte_addr,
        input logic [REGISTER_FILE_LEN-1:0] base
    );
        logic [REGISTER_FILE_LEN-1:0] rel;
        rel = byte_addr - base;
        return rel[SRAM_WORD_LEN+1:2];
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-transfer wait counter: counts up from zero after clr and flags the last cycle of a transfer.
module sram_wait_counter
    import sram_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);

    localparam logic [WAIT_CNT_LEN-1:0] WAIT_LIMIT = WAIT_CNT_LEN'(WAIT_CYCLES);

    logic [WAIT_CNT_LEN-1:0] count_q;
    logic [WAIT_CNT_LEN-1:0] count_d;

    // Next count: clear on request, otherwise advance and park at the limit
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WAIT_CNT_LEN{1'b0}};
        end else if (count_q != WAIT_LIMIT) begin
            count_d = count_q + {{(WAIT_CNT_LEN-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WAIT_CNT_LEN{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == WAIT_LIMIT);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage responder: splits each 32-bit load/store into two 16-bit SRAM transfers
// and freezes the pipeline through ready until the access completes.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int                            WAIT_CYCLES = 1,
    parameter logic [REGISTER_FILE_LEN-1:0] ADDR_OFFSET = 32'd1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rd_en,
    input  logic                          wr_en,
    input  logic [REGISTER_FILE_LEN-1:0]  address,
    input  logic [REGISTER_FILE_LEN-1:0]  wr_data,
    output logic [REGISTER_FILE_LEN-1:0]  rd_data,
    output logic                          ready,
    output logic [SRAM_ADDR_LEN-1:0]      sram_addr,
    inout  wire  [SRAM_DATA_LEN-1:0]      sram_dq,
    output logic                          sram_we_n
);

    state_e                         state_q, state_d;
    logic [SRAM_WORD_LEN-1:0]       word_q, word_d;
    logic [REGISTER_FILE_LEN-1:0]   wdata_q, wdata_d;
    logic [SRAM_DATA_LEN-1:0]       rd_lo_q, rd_lo_d;
    logic [SRAM_DATA_LEN-1:0]       rd_hi_q, rd_hi_d;
    logic [SRAM_ADDR_LEN-1:0]       sram_addr_q, sram_addr_d;
    logic                           we_n_q, we_n_d;
    logic                           dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_LEN-1:0]       dq_out_q, dq_out_d;
    logic                           in_xfer_s;
    logic                           wait_done_s;
    logic                           cnt_clr_s;
    logic                           ld_lo_s;
    logic                           ld_hi_s;

    assign in_xfer_s = (state_q == ST_RD_LO) || (state_q == ST_RD_HI) ||
                       (state_q == ST_WR_LO) || (state_q == ST_WR_HI);
    // Restart the count on every state entry, i.e. whenever a transfer is not continuing
    assign cnt_clr_s = !in_xfer_s || wait_done_s;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .done (wait_done_s)
    );

    // Next-state logic and request capture on leaving IDLE
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    state_d = ST_WR_LO;
                    word_d  = sram_word(address, ADDR_OFFSET);
                    wdata_d = wr_data;
                end else if (rd_en) begin
                    state_d = ST_RD_LO;
                    word_d  = sram_word(address, ADDR_OFFSET);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_LO: state_d = wait_done_s ? ST_RD_HI : ST_RD_LO;
            ST_RD_HI: state_d = wait_done_s ? ST_DONE  : ST_RD_HI;
            ST_WR_LO: state_d = wait_done_s ? ST_WR_HI : ST_WR_LO;
            ST_WR_HI: state_d = wait_done_s ? ST_DONE  : ST_WR_HI;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SRAM pins are registered from the upcoming state so they stay stable per transfer
    always_comb begin
        sram_addr_d = sram_addr_q;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        case (state_d)
            ST_RD_LO: sram_addr_d = {word_d, 1'b0};
            ST_RD_HI: sram_addr_d = {word_d, 1'b1};
            ST_WR_LO: begin
                sram_addr_d = {word_d, 1'b0};
                we_n_d      = 1'b0;
                dq_oe_d     = 1'b1;
                dq_out_d    = wdata_d[SRAM_DATA_LEN-1:0];
            end
            ST_WR_HI: begin
                sram_addr_d = {word_d, 1'b1};
                we_n_d      = 1'b0;
                dq_oe_d     = 1'b1;
                dq_out_d    = wdata_d[REGISTER_FILE_LEN-1:SRAM_DATA_LEN];
            end
            default: begin
                sram_addr_d = sram_addr_q;
            end
        endcase
    end

    // Read halves are sampled on the final cycle of their transfer only
    assign ld_lo_s = (state_q == ST_RD_LO) && wait_done_s;
    assign ld_hi_s = (state_q == ST_RD_HI) && wait_done_s;

    // Load-result half registers
    always_comb begin
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        if (ld_lo_s) begin
            rd_lo_d = sram_dq;
        end else begin
            rd_lo_d = rd_lo_q;
        end
        if (ld_hi_s) begin
            rd_hi_d = sram_dq;
        end else begin
            rd_hi_d = rd_hi_q;
        end
    end

    // Pipeline freeze: only IDLE without a request or the single DONE cycle lets it advance
    always_comb begin
        ready = 1'b0;
        case (state_q)
            ST_IDLE: ready = ~(rd_en | wr_en);
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_q      <= {SRAM_WORD_LEN{1'b0}};
            wdata_q     <= {REGISTER_FILE_LEN{1'b0}};
            rd_lo_q     <= {SRAM_DATA_LEN{1'b0}};
            rd_hi_q     <= {SRAM_DATA_LEN{1'b0}};
            sram_addr_q <= {SRAM_ADDR_LEN{1'b0}};
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= {SRAM_DATA_LEN{1'b0}};
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rd_lo_q     <= rd_lo_d;
            rd_hi_q     <= rd_hi_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign rd_data   = {rd_hi_q, rd_lo_q};
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;
    assign sram_dq   = dq_oe_q ? dq_out_q : {SRAM_DATA_LEN{1'bz}};

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: three instances (WAIT_CYCLES 1, 0, 3), each with
// its own SRAM model; expected results are queued when an access is launched.
module tb_sram_mem_ctrl;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        rd_en     [N];
    logic        wr_en     [N];
    logic [31:0] rd_data   [N];
    logic        ready     [N];
    logic [17:0] sram_addr [N];
    logic        we_n      [N];
    logic [15:0] dq_s      [N];
    logic [1:0]  drv_mode  [N];
    logic [15:0] probe_val;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int WCG = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [15:0] mem [0:262143];
        wire  [15:0] dq;
        logic        drv_on;
        logic [15:0] drv_val;

        // mode 1: SRAM drives stored data while not written; mode 2: fixed probe pattern
        assign drv_on  = (drv_mode[g] == 2'd2) || ((drv_mode[g] == 2'd1) && we_n[g]);
        assign drv_val = (drv_mode[g] == 2'd2) ? probe_val : mem[sram_addr[g]];
        assign dq      = drv_on ? drv_val : 16'hzzzz;
        assign dq_s[g] = dq;

        always @(posedge clk) begin
            if (!we_n[g]) mem[sram_addr[g]] <= dq;
        end

        sram_mem_ctrl #(
            .WAIT_CYCLES (WCG),
            .ADDR_OFFSET (32'd1024)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en[g]),
            .wr_en     (wr_en[g]),
            .address   (address),
            .wr_data   (wr_data),
            .rd_data   (rd_data[g]),
            .ready     (ready[g]),
            .sram_addr (sram_addr[g]),
            .sram_dq   (dq),
            .sram_we_n (we_n[g])
        );
    end

    typedef struct {
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat;
    logic [17:0] tr_addr [40];
    logic [15:0] tr_dq   [40];
    logic        tr_we   [40];
    logic        tr_rdy  [40];
    logic [31:0] tr_rd;

    function automatic int wait_of(input int gi);
        return (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    endfunction

    // Present one request starting just after a rising edge, trace each cycle until ready.
    task automatic run_access(input int gi, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d, output int l);
        l = -1;
        tr_rd = 32'hxxxxxxxx;
        address = a;
        wr_data = d;
        wr_en[gi] = w;
        rd_en[gi] = r;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tr_addr[c] = sram_addr[gi];
            tr_dq[c]   = dq_s[gi];
            tr_we[c]   = we_n[gi];
            tr_rdy[c]  = ready[gi];
            if (c > 0 && ready[gi]) begin
                l = c;
                tr_rd = rd_data[gi];
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_en[gi] = 1'b0;
        rd_en[gi] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int gi = 0; gi < N; gi++) begin
            n_checks++;
            if (ready[gi] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b expected 1", gi, ready[gi]);
            else n_pass++;
            n_checks++;
            if (rd_data[gi] !== 32'h0) $display("FAIL reset_rd_data[%0d]: got %h expected 0", gi, rd_data[gi]);
            else n_pass++;
            n_checks++;
            if (sram_addr[gi] !== 18'h0) $display("FAIL reset_sram_addr[%0d]: got %h expected 0", gi, sram_addr[gi]);
            else n_pass++;
            n_checks++;
            if (we_n[gi] !== 1'b1) $display("FAIL reset_we_n[%0d]: got %b expected 1", gi, we_n[gi]);
            else n_pass++;
        end
        drv_mode[0] = 2'd2;
        probe_val = 16'h5A5A;
        #1;
        n_checks++;
        if (dq_s[0] !== 16'h5A5A) $display("FAIL reset_dq_released: got %h expected 5a5a", dq_s[0]);
        else n_pass++;
        drv_mode[0] = 2'd1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_store();
        sb.push_back('{32'h0, 5});
        run_access(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) $display("FAIL store_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (tr_rd !== e.rd) $display("FAIL store_rd_data_kept: got %h expected %h", tr_rd, e.rd);
        else n_pass++;
        n_checks++;
        if (tr_rdy[0] !== 1'b0) $display("FAIL store_ready_c0: got %b expected 0", tr_rdy[0]);
        else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (tr_addr[c] !== ((c < 3) ? 18'd4 : 18'd5) || tr_dq[c] !== ((c < 3) ? 16'hBEEF : 16'hDEAD) || tr_we[c] !== 1'b0)
                $display("FAIL store_cycle%0d: got addr=%0d dq=%h we_n=%b expected addr=%0d dq=%h we_n=0",
                         c, tr_addr[c], tr_dq[c], tr_we[c], (c < 3) ? 4 : 5, (c < 3) ? 16'hBEEF : 16'hDEAD);
            else n_pass++;
        end
        n_checks++;
        if (tr_we[5] !== 1'b1) $display("FAIL store_we_n_done: got %b expected 1", tr_we[5]);
        else n_pass++;
        n_checks++;
        if (g_inst[0].mem[4] !== 16'hBEEF || g_inst[0].mem[5] !== 16'hDEAD)
            $display("FAIL store_sram_content: got %h_%h expected dead_beef", g_inst[0].mem[5], g_inst[0].mem[4]);
        else n_pass++;
    endtask

    task automatic test_load();
        sb.push_back('{32'hDEADBEEF, 5});
        run_access(0, 1'b0, 1'b1, 32'd1032, 32'h0, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat) $display("FAIL load_latency: got %0d expected %0d", lat, e.lat);
        else n_pass++;
        n_checks++;
        if (tr_rd !== e.rd) $display("FAIL load_rd_data: got %h expected %h", tr_rd, e.rd);
        else n_pass++;
        for (int c = 0; c <= 5; c++) begin
            n_checks++;
            if (tr_we[c] !== 1'b1) $display("FAIL load_we_n_c%0d: got %b expected 1", c, tr_we[c]);
            else n_pass++;
        end
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (tr_addr[c] !== ((c < 3) ? 18'd4 : 18'd5) || tr_dq[c] !== ((c < 3) ? 16'hBEEF : 16'hDEAD))
                $display("FAIL load_bus_c%0d: got addr=%0d dq=%h expected addr=%0d dq=%h",
                         c, tr_addr[c], tr_dq[c], (c < 3) ? 4 : 5, (c < 3) ? 16'hBEEF : 16'hDEAD);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        sb.push_back('{32'hDEADBEEF, 5});
        sb.push_back('{32'h12345678, 5});
        run_access(0, 1'b1, 1'b0, 32'd1028, 32'h12345678, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || tr_rd !== e.rd)
            $display("FAIL b2b_store: got lat=%0d rd=%h expected lat=%0d rd=%h", lat, tr_rd, e.lat, e.rd);
        else n_pass++;
        run_access(0, 1'b0, 1'b1, 32'd1028, 32'h0, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || tr_rd !== e.rd)
            $display("FAIL b2b_load: got lat=%0d rd=%h expected lat=%0d rd=%h", lat, tr_rd, e.lat, e.rd);
        else n_pass++;
        n_checks++;
        if (tr_addr[1] !== 18'd2) $display("FAIL b2b_load_addr: got %0d expected 2", tr_addr[1]);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        sb.push_back('{32'h12345678, 5});
        run_access(0, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, lat);
        e = sb.pop_front();
        n_checks++;
        if (lat != e.lat || tr_rd !== e.rd)
            $display("FAIL simul_result: got lat=%0d rd=%h expected lat=%0d rd=%h", lat, tr_rd, e.lat, e.rd);
        else n_pass++;
        n_checks++;
        if (tr_we[1] !== 1'b0 || tr_dq[1] !== 16'hF00D || tr_addr[1] !== 18'd8)
            $display("FAIL simul_write_lo: got we_n=%b dq=%h addr=%0d expected we_n=0 dq=f00d addr=8",
                     tr_we[1], tr_dq[1], tr_addr[1]);
        else n_pass++;
    endtask

    task automatic test_wrap_sweep();
        for (int gi = 0; gi < N; gi++) begin
            logic [31:0] d;
            int          exp_lat;
            d = 32'hA1B2C3D4 ^ gi;
            exp_lat = 2 * (wait_of(gi) + 1) + 1;
            run_access(gi, 1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd131072, d, lat);
            n_checks++;
            if (lat != exp_lat || tr_addr[1] !== 18'd0)
                $display("FAIL wrap_store[%0d]: got lat=%0d addr=%0d expected lat=%0d addr=0", gi, lat, tr_addr[1], exp_lat);
            else n_pass++;
            sb.push_back('{d, exp_lat});
            run_access(gi, 1'b0, 1'b1, 32'd1024, 32'h0, lat);
            e = sb.pop_front();
            n_checks++;
            if (lat != e.lat || tr_rd !== e.rd)
                $display("FAIL sweep_load[%0d]: got lat=%0d rd=%h expected lat=%0d rd=%h", gi, lat, tr_rd, e.lat, e.rd);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        address = 32'd1044;
        wr_data = 32'h0BADF00D;
        wr_en[0] = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (we_n[0] !== 1'b0 || sram_addr[0] !== 18'd11)
            $display("FAIL midrst_in_wr_hi: got we_n=%b addr=%0d expected we_n=0 addr=11", we_n[0], sram_addr[0]);
        else n_pass++;
        rst = 1'b1;
        wr_en[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (we_n[0] !== 1'b1 || rd_data[0] !== 32'h0 || ready[0] !== 1'b1)
            $display("FAIL midrst_state: got we_n=%b rd=%h ready=%b expected we_n=1 rd=0 ready=1",
                     we_n[0], rd_data[0], ready[0]);
        else n_pass++;
        drv_mode[0] = 2'd2;
        probe_val = 16'hC3C3;
        #1;
        n_checks++;
        if (dq_s[0] !== 16'hC3C3) $display("FAIL midrst_dq_released: got %h expected c3c3", dq_s[0]);
        else n_pass++;
        drv_mode[0] = 2'd1;
        @(negedge clk);
        n_checks++;
        if (ready[0] !== 1'b1 || we_n[0] !== 1'b1)
            $display("FAIL midrst_idle_hold: got ready=%b we_n=%b expected 1 1", ready[0], we_n[0]);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        address = 32'h0;
        wr_data = 32'h0;
        probe_val = 16'h0;
        for (int gi = 0; gi < N; gi++) begin
            rd_en[gi] = 1'b0;
            wr_en[gi] = 1'b0;
            drv_mode[gi] = 2'd1;
        end
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_simultaneous();
        test_wrap_sweep();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
